// File: rtl/shift_reg_pkg.sv
// Shared mode codes, FSM encoding and mode classification for the universal shift register.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Modes that move a bit out of the register and may be sequenced.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Single-step combinational shifter shared by direct and sequenced operation.
module shift_stage
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]  val,
  input  logic [MODE_W-1:0] mode,
  input  logic              msb_in,
  input  logic              lsb_in,
  input  logic [WIDTH-1:0]  i_par,
  output logic [WIDTH-1:0]  nxt,
  output logic              out_bit
);

  // One step of the selected operation; hold and reserved leave the value alone.
  always_comb begin
    nxt     = val;
    out_bit = 1'b0;
    case (mode)
      MODE_SHR: begin
        nxt     = {msb_in, val[WIDTH-1:1]};
        out_bit = val[0];
      end
      MODE_SHL: begin
        nxt     = {val[WIDTH-2:0], lsb_in};
        out_bit = val[WIDTH-1];
      end
      MODE_LOAD: nxt = i_par;
      MODE_ROR: begin
        nxt     = {val[0], val[WIDTH-1:1]};
        out_bit = val[0];
      end
      MODE_ROL: begin
        nxt     = {val[WIDTH-2:0], val[WIDTH-1]};
        out_bit = val[WIDTH-1];
      end
      MODE_ASR: begin
        nxt     = {val[WIDTH-1], val[WIDTH-1:1]};
        out_bit = val[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with direct modes and a start/busy/done sequenced N-step shift.
module univ_shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic              CLK,
  input  logic              Clear_b,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  I_par,
  input  logic              MSB_in,
  input  logic              LSB_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  cnt,
  output logic [WIDTH-1:0]  A_par,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic [MODE_W-1:0] mode_q, mode_d;

  logic [MODE_W-1:0] stage_mode;
  logic [WIDTH-1:0]  stage_nxt;
  logic              stage_out;
  logic              seq_req;

  // A sequenced request is only recognised for shift-class modes while idle.
  assign seq_req = (state_q == ST_IDLE) && start && is_shift_mode(mode);

  // RUN replays the latched mode; IDLE executes live mode unless a request is taken.
  assign stage_mode = (state_q == ST_RUN)                ? mode_q :
                      ((state_q == ST_IDLE) && !seq_req) ? mode   : MODE_HOLD;

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .val     (a_q),
    .mode    (stage_mode),
    .msb_in  (MSB_in),
    .lsb_in  (LSB_in),
    .i_par   (I_par),
    .nxt     (stage_nxt),
    .out_bit (stage_out)
  );

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d = state_q;
    a_d     = stage_nxt;
    ser_d   = ser_q;
    steps_d = steps_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (is_shift_mode(stage_mode)) ser_d = stage_out;

    case (state_q)
      ST_IDLE: begin
        if (seq_req) begin
          mode_d  = mode;
          steps_d = cnt;
          state_d = (cnt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        steps_d = steps_q - CNT_W'(1);
        if (steps_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      steps_q <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      steps_q <= steps_d;
      mode_q  <= mode_d;
    end
  end

  assign A_par   = a_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Directed and randomized checks of the universal shift register against an arithmetic model.
module tb_univ_shift_reg_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             CLK = 1'b0;
  logic             Clear_b;
  logic [2:0]       mode;
  logic [WIDTH-1:0] I_par;
  logic             MSB_in, LSB_in, start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] A_par;
  logic             ser_out, busy, done;

  int checks = 0;
  int failures = 0;
  int m_a = 0;
  int m_ser = 0;

  univ_shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Clear_b(Clear_b), .mode(mode), .I_par(I_par),
    .MSB_in(MSB_in), .LSB_in(LSB_in), .start(start), .cnt(cnt),
    .A_par(A_par), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ea, input int es, input int eb, input int ed);
    chk($sformatf("%s.A", tag), int'(A_par), ea);
    chk($sformatf("%s.ser", tag), int'(ser_out), es);
    chk($sformatf("%s.busy", tag), int'(busy), eb);
    chk($sformatf("%s.done", tag), int'(done), ed);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic bit shift_class(input int m);
    return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
  endfunction

  // Value after one step, using integer arithmetic on a 4-bit quantity.
  function automatic int ref_step(input int m, input int v, input int msb, input int lsb,
                                  input int ip, output int o);
    o = -1;
    case (m)
      1: begin o = v % 2; return v / 2 + msb * 8; end
      2: begin o = v / 8; return (v * 2) % 16 + lsb; end
      3: return ip;
      4: begin o = v % 2; return v / 2 + o * 8; end
      5: begin o = v / 8; return (v * 2) % 16 + o; end
      6: begin o = v % 2; return v / 2 + (v / 8) * 8; end
      default: return v;
    endcase
  endfunction

  task automatic do_direct(input string tag, input int m, input int ip, input int msb,
                           input int lsb, input bit st);
    int o;
    mode = 3'(m); I_par = 4'(ip); MSB_in = 1'(msb); LSB_in = 1'(lsb); start = st;
    cnt = 3'($urandom_range(7, 0));
    tick();
    m_a = ref_step(m, m_a, msb, lsb, ip, o);
    if (o >= 0) m_ser = o;
    chk_all(tag, m_a, m_ser, 0, 0);
    start = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int m, input int c, input int msb,
                         input int lsb, input bit junk);
    int o;
    mode = 3'(m); cnt = 3'(c); start = 1'b1; MSB_in = 1'(msb); LSB_in = 1'(lsb);
    tick();
    chk_all($sformatf("%s.req", tag), m_a, m_ser, (c != 0) ? 1 : 0, (c == 0) ? 1 : 0);
    start = junk; mode = junk ? 3'd3 : 3'd0;
    I_par = 4'($urandom_range(15, 0)); cnt = 3'($urandom_range(7, 0));
    for (int i = 1; i <= c; i++) begin
      tick();
      m_a = ref_step(m, m_a, msb, lsb, 0, o);
      m_ser = o;
      chk_all($sformatf("%s.s%0d", tag, i), m_a, m_ser, (i < c) ? 1 : 0, (i == c) ? 1 : 0);
      if (junk) begin
        start = 1'(i % 2);
        mode = 3'($urandom_range(7, 0));
        I_par = 4'($urandom_range(15, 0));
      end
    end
    if (junk) begin start = 1'b1; mode = 3'd1; end
    tick();
    start = 1'b0; mode = 3'd0;
    chk_all($sformatf("%s.idle", tag), m_a, m_ser, 0, 0);
  endtask

  initial begin
    Clear_b = 1'b0; mode = 3'd0; I_par = '0; MSB_in = 1'b0; LSB_in = 1'b0;
    start = 1'b0; cnt = '0;
    #3;
    chk_all("reset", 0, 0, 0, 0);
    #4 Clear_b = 1'b1;
    tick();

    // Asynchronous clear between edges.
    do_direct("t1_load", 3, 'hA, 0, 0, 0);
    #2 Clear_b = 1'b0;
    #1 chk_all("t1_clear", 0, 0, 0, 0);
    Clear_b = 1'b1;
    m_a = 0; m_ser = 0;

    // Direct modes.
    do_direct("t2_load", 3, 'hA, 0, 0, 0);
    chk("t2_load_const", int'(A_par), 'hA);
    do_direct("t2_shr", 1, 0, 1, 0, 0);
    chk("t2_shr_const", int'(A_par), 'hD);
    do_direct("t2_shl", 2, 0, 0, 1, 0);
    chk("t2_shl_const", int'(A_par), 'hB);
    do_direct("t2_hold", 0, 5, 1, 1, 1);
    chk("t2_hold_const", int'(A_par), 'hB);
    do_direct("t2_rsvd", 7, 5, 1, 1, 1);

    // Sequenced ROL by 3.
    do_direct("t3_load", 3, 'h8, 0, 0, 0);
    run_seq("t3", 5, 3, 0, 0, 0);
    chk("t3_const", int'(A_par), 'h4);

    // Sequenced ASR beyond width, then zero-count request.
    do_direct("t4_load", 3, 'h9, 0, 0, 0);
    run_seq("t4a", 6, 6, 0, 0, 0);
    chk("t4a_const_a", int'(A_par), 'hF);
    chk("t4a_const_ser", int'(ser_out), 1);
    run_seq("t4b", 6, 0, 0, 0, 0);

    // Sequenced SHL with ignored controls during RUN and DONE.
    do_direct("t5_load", 3, 'h6, 0, 0, 0);
    run_seq("t5", 2, 2, 0, 1, 1);
    chk("t5_const_a", int'(A_par), 'hB);
    chk("t5_const_ser", int'(ser_out), 1);

    // Clear during a running ROR aborts with no done pulse.
    do_direct("t6_load", 3, 'h5, 0, 0, 0);
    mode = 3'd4; cnt = 3'd5; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'd0;
    tick();
    tick();
    chk("t6_busy_mid", int'(busy), 1);
    #2 Clear_b = 1'b0;
    #1 chk_all("t6_clear", 0, 0, 0, 0);
    Clear_b = 1'b1;
    m_a = 0; m_ser = 0;
    tick();
    chk_all("t6_after", 0, 0, 0, 0);
    do_direct("t6_load2", 3, 'h3, 0, 0, 0);
    run_seq("t6_seq", 4, 5, 0, 0, 0);
    chk("t6_const", int'(A_par), 'h9);

    // Randomized direct operations.
    for (int i = 0; i < 40; i++) begin
      int m;
      bit st;
      m = int'($urandom_range(7, 0));
      st = shift_class(m) ? 1'b0 : 1'($urandom_range(1, 0));
      do_direct($sformatf("rd%0d", i), m, int'($urandom_range(15, 0)),
                int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), st);
    end

    // Randomized sequenced commands.
    for (int i = 0; i < 12; i++) begin
      int m;
      case ($urandom_range(4, 0))
        0: m = 1;
        1: m = 2;
        2: m = 4;
        3: m = 5;
        default: m = 6;
      endcase
      run_seq($sformatf("rs%0d", i), m, int'($urandom_range(7, 0)),
              int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
